// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and constants for the timer array.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Period storage is fixed at 32 bits so the struct is usable for any CNT_W <= 32.
    localparam int unsigned TMR_PERIOD_W       = 32;
    localparam int unsigned TMR_DEFAULT_PERIOD = 100_000_000;

    typedef enum logic {
        TMR_PERIODIC = 1'b0,
        TMR_ONESHOT  = 1'b1
    } tmr_mode_e;

    typedef struct packed {
        logic [TMR_PERIOD_W-1:0] period;
        tmr_mode_e               mode;
    } tmr_cfg_t;

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : timer_channel
// Description : One timer channel: counter, mode, sticky done and pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned      CNT_W          = 27,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(TMR_DEFAULT_PERIOD)
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_tick,
    input  logic     i_en,
    input  logic     i_restart,
    input  logic     i_cfg_we,
    input  tmr_cfg_t i_cfg,
    output logic     o_pulse,
    output logic     o_done,
    output logic     o_busy
);

    tmr_cfg_t         r_cfg;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             r_pulse;
    logic             r_busy;

    logic             w_advance;
    logic             w_terminal;

    assign w_advance  = i_tick & i_en & ~r_done;
    // Period is never zero (rejected at write), so period-1 cannot underflow.
    assign w_terminal = w_advance &
                        (TMR_PERIOD_W'(r_count) >= (r_cfg.period - TMR_PERIOD_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg   <= '{period: TMR_PERIOD_W'(DEFAULT_PERIOD), mode: TMR_PERIODIC};
            r_count <= '0;
            r_done  <= 1'b0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_busy  <= i_en & ~r_done;
            r_pulse <= 1'b0;
            // Config write outranks restart, which outranks a coincident terminal.
            if (i_cfg_we) begin
                r_cfg   <= i_cfg;
                r_count <= '0;
                r_done  <= 1'b0;
            end else if (i_restart) begin
                r_count <= '0;
                r_done  <= 1'b0;
            end else if (w_terminal) begin
                r_count <= '0;
                r_pulse <= 1'b1;
                if (r_cfg.mode == TMR_ONESHOT) begin
                    r_done <= 1'b1;
                end
            end else if (w_advance) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_pulse = r_pulse;
    assign o_done  = r_done;
    assign o_busy  = r_busy;

endmodule
`default_nettype wire

// File: rtl/timer_array.sv
`default_nettype none
// ============================================================================
// Module      : timer_array
// Description : N_CH independent timers sharing a prescaler and config port.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_array
    import timer_pkg::*;
#(
    parameter int unsigned      N_CH           = 9,
    parameter int unsigned      CNT_W          = 27,
    parameter int unsigned      DIV_W          = 8,
    parameter logic [N_CH-1:0]  SLOW_MASK      = 9'b111_000000,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(TMR_DEFAULT_PERIOD),
    localparam int unsigned     c_ch_w         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   en,
    input  logic [N_CH-1:0]   restart,
    input  logic              cfg_we,
    input  logic [c_ch_w-1:0] cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    input  logic [DIV_W-1:0]  presc_div,
    output logic [N_CH-1:0]   pulse,
    output logic [N_CH-1:0]   done,
    output logic [N_CH-1:0]   busy,
    output logic              cfg_err
);

    localparam logic [c_ch_w:0] c_ch_limit = (c_ch_w + 1)'(N_CH);

    logic [DIV_W-1:0] r_presc_cnt;
    logic             r_cfg_err;
    logic             w_strobe;
    logic             w_cfg_bad;
    logic             w_cfg_ok;
    tmr_cfg_t         w_cfg_new;

    // The >= wrap recovers immediately when presc_div is lowered below the count.
    assign w_strobe = (r_presc_cnt == presc_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc_cnt <= '0;
        end else if (r_presc_cnt >= presc_div) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + DIV_W'(1);
        end
    end

    assign w_cfg_bad = ({1'b0, cfg_ch} >= c_ch_limit) || (cfg_period == '0);
    assign w_cfg_ok  = cfg_we & ~w_cfg_bad;
    assign w_cfg_new = '{period: TMR_PERIOD_W'(cfg_period),
                         mode:   (cfg_oneshot ? TMR_ONESHOT : TMR_PERIODIC)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we & w_cfg_bad;
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        timer_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (SLOW_MASK[g] ? w_strobe : 1'b1),
            .i_en      (en[g]),
            .i_restart (restart[g]),
            .i_cfg_we  (w_cfg_ok && (cfg_ch == c_ch_w'(g))),
            .i_cfg     (w_cfg_new),
            .o_pulse   (pulse[g]),
            .o_done    (done[g]),
            .o_busy    (busy[g])
        );
    end

endmodule
`default_nettype wire

// File: doc/timer_array.md
TIMER_ARRAY -- requirements
Module: timer_array

Interface
REQ-001 Parameter N_CH, default 9, number of timer channels (1..32).
REQ-002 Parameter CNT_W, default 27, width of period and counter.
REQ-003 Parameter DIV_W, default 8, width of the shared prescaler divide value.
REQ-004 Parameter SLOW_MASK [N_CH], default 9'b111_000000, bit=1 means the channel counts prescaler strobes, not clock cycles.
REQ-005 Parameter DEFAULT_PERIOD [CNT_W], default 100_000_000 (one pulse per second at 100 MHz).
REQ-006 clk  input  1  single system clock; all logic in this domain.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 en  input  N_CH  per-channel run enable; low pauses the counter.
REQ-009 restart  input  N_CH  per-channel one-cycle strobe: zero counter, clear done.
REQ-010 cfg_we  input  1  configuration write strobe.
REQ-011 cfg_ch  input  $clog2(N_CH) (min 1)  channel addressed by cfg_we.
REQ-012 cfg_period  input  CNT_W  new period in ticks.
REQ-013 cfg_oneshot  input  1  new mode: 1 one-shot, 0 periodic.
REQ-014 presc_div  input  DIV_W  prescaler: strobe every presc_div+1 cycles.
REQ-015 pulse  output  N_CH  one-cycle terminal-count pulse per channel.
REQ-016 done  output  N_CH  sticky one-shot completion flag.
REQ-017 busy  output  N_CH  en & ~done per channel, registered.
REQ-018 cfg_err  output  1  one-cycle flag: rejected configuration write.

Function
REQ-019 Tick: fast channel ticks every cycle; slow channel ticks on prescaler strobe.
REQ-020 Prescaler counts 0..presc_div, strobes at presc_div, wraps to 0; presc_div=0 gives strobe every cycle; count >= new presc_div wraps to 0 next cycle.
REQ-021 Channel counter increments on tick when en=1 and done=0; holds otherwise.
REQ-022 Terminal: tick while count==period-1; counter -> 0, pulse asserted the following cycle (latency 1), exactly one cycle wide.
REQ-023 Periodic mode: counting continues after terminal; period P gives pulse every P ticks; P=1 gives pulse on every tick.
REQ-024 One-shot mode: terminal sets done, counter stops at 0; no further pulse until restart or cfg write.
REQ-025 Valid cfg_we (cfg_ch<N_CH, cfg_period!=0): next cycle period/mode updated, count=0, done=0; no pulse from that cycle's tick.
REQ-026 Invalid cfg_we (cfg_ch>=N_CH or cfg_period==0): no state change, cfg_err=1 next cycle.
REQ-027 restart: count=0, done=0 next cycle; suppresses a coincident terminal (no pulse, done stays 0).
REQ-028 cfg_we and restart same channel same cycle: cfg write applied, restart redundant.
REQ-029 Channels fully independent; simultaneous terminals on several channels all pulse same cycle.
REQ-030 en deassert mid-count: count frozen; resumes from frozen value on reassert.
REQ-031 Counter arithmetic CNT_W bits, never exceeds period-1; no wrap-around beyond period.

Reset
REQ-032 rst_n low asynchronously: all counts 0, prescaler 0, period=DEFAULT_PERIOD, mode periodic, pulse=0, done=0, busy=0, cfg_err=0.
REQ-033 Reset deassertion mid-operation: counting restarts from 0 on first clk edge with rst_n high.

Structure
REQ-034 Package timer_pkg holds mode enum (TMR_PERIODIC, TMR_ONESHOT), channel config struct {period, mode}, DEFAULT_PERIOD constant.
REQ-035 Sub-module timer_channel (one counter, mode, done, pulse), instantiated N_CH times via generate; prescaler and cfg decode in timer_array.

Verification
REQ-036 Reset, en=all 1, DEFAULT_PERIOD overridden to 10 -> fast channels pulse at cycles 10, 20, 30 after reset release, width 1.
REQ-037 presc_div=3, slow channel period 5 -> pulse every 20 cycles; change presc_div to 1 mid-count -> period becomes 10 cycles.
REQ-038 cfg ch2 period 4 one-shot -> single pulse 4 cycles later, done[2]=1, busy[2]=0; restart[2] -> another pulse 4 cycles later.
REQ-039 restart coincident with terminal tick on ch0 -> no pulse, count=0, next pulse one full period later.
REQ-040 cfg_we cfg_ch=N_CH, then cfg_period=0 -> cfg_err pulses twice, no channel state changes.
REQ-041 rst_n asserted mid-count and mid-pulse -> pulse/done/busy drop immediately (asynchronously); period reverts to DEFAULT_PERIOD.
